// File: rtl/mac_simd_seq.sv
// mac_simd_seq: lane-serial SIMD multiply-accumulate peripheral.
// A rising START latches LANES packed operand pairs. Their dot product is
// then accumulated into MAC_OUT, one lane per clock with lane 0 first.
// Signed/unsigned, wrap/saturate and fresh/accumulate modes are supported.
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   reset     synchronous, active-high reset
//   MAC_INA   operand A; lane i = [i*LANE_W +: LANE_W]
//   MAC_INB   operand B; same packing as MAC_INA
//   MAC_CTRL  [7] EN, [6] CLR, [5] IRQ_ACK, [4] reserved,
//             [3] SAT, [2] SIGNED, [1] ACCUM, [0] START
//   MAC_OUT   accumulator register (ACC_W bits)
//   IRQ_MAC   sticky completion interrupt
//   MAC_BUSY  high while a lane-serial run is in progress
//   MAC_OVF   sticky overflow/saturation flag
module mac_simd_seq #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*LANE_W-1:0]   MAC_INA,
  input  logic [LANES*LANE_W-1:0]   MAC_INB,
  input  logic [7:0]                MAC_CTRL,
  output logic [ACC_W-1:0]          MAC_OUT,
  output logic                      IRQ_MAC,
  output logic                      MAC_BUSY,
  output logic                      MAC_OVF
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW    = 2 * LANE_W;
  localparam int unsigned EW    = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    start_prev;
  logic [LANES*LANE_W-1:0] a_q;
  logic [LANES*LANE_W-1:0] b_q;
  logic                    sgn_q;
  logic                    sat_q;

  logic en, clr, ack, sat, sgn, accum, start, start_edge;
  logic unused_ctrl;

  assign en          = MAC_CTRL[7];
  assign clr         = MAC_CTRL[6];
  assign ack         = MAC_CTRL[5];
  assign sat         = MAC_CTRL[3];
  assign sgn         = MAC_CTRL[2];
  assign accum       = MAC_CTRL[1];
  assign start       = MAC_CTRL[0];
  assign unused_ctrl = MAC_CTRL[4];
  assign start_edge  = start & ~start_prev;

  logic [LANE_W-1:0] a_lane, b_lane;
  logic [PW-1:0]     a_ext, b_ext, prod;
  logic [EW-1:0]     p_ext, acc_ext, sum;
  logic              step_ovf;
  logic [ACC_W-1:0]  step_val;
  logic              last_lane;

  // One lane step. The operands are extended to the full product width, so
  // the low PW bits of the product are correct for both signednesses. The
  // sum needs one extra bit to expose any excursion beyond the ACC_W range.
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_lane = a_q[i*LANE_W +: LANE_W];
        b_lane = b_q[i*LANE_W +: LANE_W];
      end
    end
    a_ext   = {{LANE_W{a_lane[LANE_W-1] & sgn_q}}, a_lane};
    b_ext   = {{LANE_W{b_lane[LANE_W-1] & sgn_q}}, b_lane};
    prod    = a_ext * b_ext;
    p_ext   = {{(EW-PW){prod[PW-1] & sgn_q}}, prod};
    acc_ext = {MAC_OUT[ACC_W-1] & sgn_q, MAC_OUT};
    sum     = acc_ext + p_ext;

    if (sgn_q) begin
      step_ovf = sum[EW-1] ^ sum[ACC_W-1];
    end else begin
      step_ovf = sum[ACC_W];
    end

    step_val = sum[ACC_W-1:0];
    if (step_ovf && sat_q) begin
      if (!sgn_q) begin
        step_val = '1;
      end else if (sum[EW-1]) begin
        step_val = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        step_val = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end

    last_lane = (idx == IDX_W'(LANES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      start_prev <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      MAC_OUT    <= '0;
      IRQ_MAC    <= 1'b0;
      MAC_BUSY   <= 1'b0;
      MAC_OVF    <= 1'b0;
    end else begin
      start_prev <= start;

      // The acknowledge is written first, so a completion on this edge wins.
      if (ack) begin
        IRQ_MAC <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (en) begin
            if (clr) begin
              MAC_OUT <= '0;
              MAC_OVF <= 1'b0;
            end else if (start_edge) begin
              a_q   <= MAC_INA;
              b_q   <= MAC_INB;
              sgn_q <= sgn;
              sat_q <= sat;
              if (!accum) begin
                MAC_OUT <= '0;
                MAC_OVF <= 1'b0;
              end
              IRQ_MAC  <= 1'b0;
              idx      <= '0;
              state    <= RUN;
              MAC_BUSY <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!en) begin
            state    <= IDLE;
            MAC_BUSY <= 1'b0;
          end else begin
            MAC_OUT <= step_val;
            if (step_ovf) begin
              MAC_OVF <= 1'b1;
            end
            if (last_lane) begin
              IRQ_MAC  <= 1'b1;
              state    <= DONE;
              MAC_BUSY <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          MAC_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_simd_seq.sv
// Self-checking bench for mac_simd_seq. The reference model evaluates the
// dot product with plain integer arithmetic and clamps or wraps after each
// lane.
module tb_mac_simd_seq;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int ACC_W  = 16;
  localparam int DW     = LANES * LANE_W;

  logic              clk;
  logic              reset;
  logic [DW-1:0]     ina, inb;
  logic [7:0]        ctrl;
  logic [ACC_W-1:0]  mac_out;
  logic              irq, busy, ovf;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0]  m_out;
  bit                m_ovf;

  localparam logic [DW-1:0] VA = 32'h33F08235;
  localparam logic [DW-1:0] VB = 32'h60B2D903;

  mac_simd_seq #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .MAC_INA  (ina),
    .MAC_INB  (inb),
    .MAC_CTRL (ctrl),
    .MAC_OUT  (mac_out),
    .IRQ_MAC  (irq),
    .MAC_BUSY (busy),
    .MAC_OVF  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  // Model of one run over the first nl lanes.
  task automatic model_run(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit sgn, input bit sat, input bit accum,
                           input int nl);
    longint acc, x, y, lo, hi, span;
    logic [LANE_W-1:0] la, lb;
    span = longint'(1) << ACC_W;
    lo   = sgn ? -(span / 2) : 0;
    hi   = sgn ? (span / 2) - 1 : span - 1;
    if (!accum) begin
      m_out = '0;
      m_ovf = 0;
    end
    acc = longint'(m_out);
    if (sgn && acc > hi) acc -= span;
    for (int i = 0; i < nl; i++) begin
      la = a[i*LANE_W +: LANE_W];
      lb = b[i*LANE_W +: LANE_W];
      x  = sgn ? longint'($signed(la)) : longint'(la);
      y  = sgn ? longint'($signed(lb)) : longint'(lb);
      acc += x * y;
      if (acc < lo || acc > hi) begin
        m_ovf = 1;
        if (sat) acc = (acc < lo) ? lo : hi;
        else begin
          acc = acc & (span - 1);
          if (sgn && acc > hi) acc -= span;
        end
      end
    end
    m_out = acc[ACC_W-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run with cs, then holds cr and scrambles the operand inputs.
  // Returns after the run leaves RUN, or after a cycle budget expires.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [7:0] cs, input logic [7:0] cr,
                        output int busy_n);
    ina  = a;
    inb  = b;
    ctrl = cs;
    tick();
    ctrl   = cr;
    ina    = $urandom;
    inb    = $urandom;
    busy_n = 0;
    while (busy && busy_n < 4 * LANES + 8) begin
      tick();
      busy_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl  = 8'h00;
    tick();
    tick();
    checks++; if (mac_out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", mac_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    reset = 1'b0;
    m_out = '0;
    m_ovf = 0;
    ctrl  = 8'h80;
    tick();
  endtask

  task automatic test_unsigned_wrap();
    int n;
    model_run(VA, VB, 0, 0, 0, LANES);
    run_op(VA, VB, 8'h81, 8'h80, n);
    checks++; if (n != LANES) begin errors++; $display("FAIL uw_busy_cycles: got %0d expected %0d", n, LANES); end
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL uw_out_model: got %h expected %h", mac_out, m_out); end
    checks++; if (mac_out !== 16'h28D1) begin errors++; $display("FAIL uw_out: got %h expected 28d1", mac_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL uw_ovf: got %b expected 1", ovf); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL uw_irq: got %b expected 1", irq); end
    ctrl = 8'hA0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL uw_irq_ack: got %b expected 0", irq); end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_modes();
    logic [DW-1:0]    ta [4] = '{VA, VA, 32'h80808080, 32'h80808080};
    logic [DW-1:0]    tb [4] = '{VB, VB, 32'h80808080, 32'h80808080};
    logic [7:0]       tc [4] = '{8'h89, 8'h8D, 8'h8D, 8'h85};
    logic [ACC_W-1:0] te [4] = '{16'hFFFF, 16'h2BD1, 16'h7FFF, 16'h0000};
    bit               tv [4] = '{1, 0, 1, 1};
    int n;
    for (int i = 0; i < 4; i++) begin
      model_run(ta[i], tb[i], tc[i][2], tc[i][3], 0, LANES);
      run_op(ta[i], tb[i], tc[i], tc[i] & 8'hFE, n);
      checks++; if (mac_out !== te[i]) begin errors++; $display("FAIL mode%0d_out: got %h expected %h", i, mac_out, te[i]); end
      checks++; if (mac_out !== m_out) begin errors++; $display("FAIL mode%0d_out_model: got %h expected %h", i, mac_out, m_out); end
      checks++; if (ovf !== tv[i]) begin errors++; $display("FAIL mode%0d_ovf: got %b expected %b", i, ovf, tv[i]); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mode%0d_irq: got %b expected 1", i, irq); end
      ctrl = 8'hA0;
      tick();
    end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_accumulate();
    int n;
    model_run(VA, VB, 0, 0, 0, LANES);
    run_op(VA, VB, 8'h81, 8'h80, n);
    ctrl = 8'hA0;
    tick();
    ctrl = 8'h82;
    tick();
    model_run(VA, VB, 0, 0, 1, LANES);
    run_op(VA, VB, 8'h83, 8'h82, n);
    checks++; if (mac_out !== 16'h51A2) begin errors++; $display("FAIL acc_out: got %h expected 51a2", mac_out); end
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL acc_out_model: got %h expected %h", mac_out, m_out); end
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL acc_ovf: got %b expected %b", ovf, m_ovf); end
    ctrl = 8'hA0;
    tick();
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_start_level();
    int  busy_n = 0;
    int  irq_rise = 0;
    bit  prev_irq;
    logic [DW-1:0] a, b;
    a = $urandom;
    b = $urandom;
    model_run(a, b, 0, 0, 0, LANES);
    prev_irq = irq;
    ina  = a;
    inb  = b;
    ctrl = 8'h81;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_n++;
      if (irq && !prev_irq) irq_rise++;
      prev_irq = irq;
    end
    checks++; if (busy_n != LANES) begin errors++; $display("FAIL level_busy_cycles: got %0d expected %0d", busy_n, LANES); end
    checks++; if (irq_rise != 1) begin errors++; $display("FAIL level_irq_count: got %0d expected 1", irq_rise); end
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL level_out: got %h expected %h", mac_out, m_out); end
    ctrl = 8'hA0;
    tick();
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_random();
    int n;
    logic [DW-1:0] a, b;
    logic [7:0] cs, cr;
    bit sgn, sat, accum;
    for (int it = 0; it < 40; it++) begin
      a     = $urandom;
      b     = $urandom;
      sgn   = 1'($urandom_range(0, 1));
      sat   = 1'($urandom_range(0, 1));
      accum = 1'($urandom_range(0, 1));
      cs    = {1'b1, 3'b000, sat, sgn, accum, 1'b1};
      cr    = cs & 8'hFE;
      cr[5] = 1'($urandom_range(0, 1));
      model_run(a, b, sgn, sat, accum, LANES);
      run_op(a, b, cs, cr, n);
      checks++; if (n != LANES) begin errors++; $display("FAIL rnd%0d_busy_cycles: got %0d expected %0d", it, n, LANES); end
      checks++; if (mac_out !== m_out) begin errors++; $display("FAIL rnd%0d_out: got %h expected %h (ctrl %h)", it, mac_out, m_out, cs); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %b expected %b", it, ovf, m_ovf); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rnd%0d_irq: got %b expected 1", it, irq); end
      ctrl = 8'hA0;
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rnd%0d_irq_ack: got %b expected 0", it, irq); end
    end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_irq_ack_same_edge();
    int n;
    model_run(VA, VB, 1, 0, 0, LANES);
    run_op(VA, VB, 8'h85, 8'hA4, n);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ack_same_edge_irq: got %b expected 1", irq); end
    checks++; if (mac_out !== 16'h2BD1) begin errors++; $display("FAIL ack_same_edge_out: got %h expected 2bd1", mac_out); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_after_irq: got %b expected 0", irq); end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_abort();
    logic [DW-1:0] a, b;
    a = $urandom;
    b = $urandom;
    model_run(a, b, 0, 0, 0, 1);
    ina  = a;
    inb  = b;
    ctrl = 8'h81;
    tick();
    ctrl = 8'h80;
    tick();
    ctrl = 8'h00;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b expected 0", irq); end
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL abort_out: got %h expected %h", mac_out, m_out); end
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL abort_ovf: got %b expected %b", ovf, m_ovf); end
    tick();
    tick();
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL abort_hold_out: got %h expected %h", mac_out, m_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_hold_irq: got %b expected 0", irq); end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_en_hold();
    int n;
    model_run(VA, VB, 0, 0, 0, LANES);
    run_op(VA, VB, 8'h81, 8'h80, n);
    ctrl = 8'hA0;
    tick();
    ctrl = 8'h01;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en0_start_busy: got %b expected 0", busy); end
    ctrl = 8'h40;
    tick();
    checks++; if (mac_out !== m_out) begin errors++; $display("FAIL en0_clr_out: got %h expected %h", mac_out, m_out); end
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL en0_clr_ovf: got %b expected %b", ovf, m_ovf); end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_clr_start();
    ctrl = 8'hC1;
    tick();
    m_out = '0;
    m_ovf = 0;
    checks++; if (mac_out !== '0) begin errors++; $display("FAIL clr_out: got %h expected 0", mac_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
    ctrl = 8'h81;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_no_run: got %b expected 0", busy); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_no_irq: got %b expected 0", irq); end
    ctrl = 8'h80;
    tick();
  endtask

  task automatic test_reset_mid();
    ina  = $urandom;
    inb  = $urandom;
    ctrl = 8'h85;
    tick();
    ctrl = 8'h84;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (mac_out !== '0) begin errors++; $display("FAIL rstmid_out: got %h expected 0", mac_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b expected 0", irq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", ovf); end
    reset = 1'b0;
    m_out = '0;
    m_ovf = 0;
    ctrl  = 8'h80;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    ctrl  = 8'h00;
    ina   = '0;
    inb   = '0;
    m_out = '0;
    m_ovf = 0;
    test_reset();
    test_unsigned_wrap();
    test_modes();
    test_accumulate();
    test_start_level();
    test_irq_ack_same_edge();
    test_random();
    test_abort();
    test_en_hold();
    test_clr_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_simd_seq.md
Name: mac_simd_seq

Overview:
- Parametrised successor to the single-lane MAC.
- Each of MAC_INA/MAC_INB is LANES packed operands of LANE_W bits.
- On a START edge, both operands are latched and a lane-serial dot product is accumulated into an ACC_W-bit accumulator, one lane per clock.
- Supports signed/unsigned, wrap/saturate and fresh/accumulate modes, a sticky overflow flag and a completion interrupt.
- Sits on the peripheral control bus beside the existing MAC unit.

Parameters:
- LANES, 4, number of packed operand lanes (>=1).
- LANE_W, 8, bits per lane operand.
- ACC_W, 16, accumulator/output width; must be >= 2*LANE_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- MAC_INA  in  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W].
- MAC_INB  in  LANES*LANE_W  operand B, same packing.
- MAC_CTRL  in  8  control:
  - [7] EN
  - [6] CLR
  - [5] IRQ_ACK
  - [4] reserved, ignored
  - [3] SAT
  - [2] SIGNED
  - [1] ACCUM
  - [0] START
- MAC_OUT  out  ACC_W  accumulator register, driven directly.
- IRQ_MAC  out  1  sticky completion interrupt.
- MAC_BUSY  out  1  high while in RUN.
- MAC_OVF  out  1  sticky overflow/saturation flag.

Behaviour:
- Reset: MAC_OUT=0, IRQ_MAC=0, MAC_BUSY=0, MAC_OVF=0, FSM=IDLE, lane index=0, START history=0.
- START detection: rising edge only (START=1 this edge, 0 at previous edge). Level-high START does not retrigger.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - EN=0: hold all state.
  - EN=1 and CLR=1: MAC_OUT<=0 and MAC_OVF<=0. CLR has priority over START on the same edge; that START is dropped.
  - EN=1 and START edge: latch A, B, SIGNED and SAT.
    - ACCUM=0: MAC_OUT<=0 and MAC_OVF<=0.
    - ACCUM=1: MAC_OUT is kept.
    - Clear IRQ_MAC, set lane index=0, go to RUN.
- RUN (MAC_BUSY=1):
  - Each edge: p = latched A[idx]*B[idx], full 2*LANE_W product; signed uses two's-complement operands.
  - p is sign- or zero-extended to ACC_W+1 bits and added to MAC_OUT, also extended to ACC_W+1 bits.
  - Range is the ACC_W-bit signed or unsigned range. Out of range sets MAC_OVF.
  - SAT=1: clamp to the range limit (signed 0x7FFF/0x8000, unsigned 0xFFFF for ACC_W=16). SAT=0: wrap to low ACC_W bits.
  - Saturation is applied per step, lane 0 first.
  - On the edge processing lane LANES-1: IRQ_MAC<=1, go to DONE.
  - Latency: START edge sampled at edge k gives final MAC_OUT and IRQ_MAC=1 at edge k+LANES.
  - START, CLR and input changes in RUN are ignored; operands are latched.
  - EN=0 in RUN aborts: next edge go to IDLE, MAC_OUT keeps the partial sum, IRQ_MAC stays 0, MAC_OVF keeps any value set.
- DONE: one cycle, unconditional return to IDLE; MAC_BUSY=0.
- IRQ_MAC: cleared by IRQ_ACK=1 in any state, by reset, or by a new accepted START. If set and cleared on the same edge (last lane plus IRQ_ACK), the set wins.
- Reset mid-operation overrides everything; all outputs return to reset values on that edge.
- LANES=1: RUN lasts exactly one edge.

Test Plan:
- Unsigned wrap (SAT=0, SIGNED=0, ACCUM=0): A=0x33F08235, B=0x60B2D903, CTRL=0x81.
  - MAC_BUSY high for 4 cycles.
  - At edge k+4: MAC_OUT=0x28D1, MAC_OVF=1, IRQ_MAC=1.
  - IRQ_ACK (CTRL=0xA0) then clears IRQ_MAC.
- Unsigned saturate (SAT=1), same operands: MAC_OUT=0xFFFF, MAC_OVF=1, IRQ_MAC=1.
- Signed, no overflow (SIGNED=1, SAT=1), same operands: MAC_OUT=0x2BD1, MAC_OVF=0.
- Signed saturate: A=B=0x80808080, SIGNED=1.
  - SAT=1: MAC_OUT=0x7FFF, MAC_OVF=1.
  - SAT=0: MAC_OUT=0x0000, MAC_OVF=1.
- Accumulate: after the first test, CTRL=0x82 for one edge, then 0x83 with the same operands: MAC_OUT=0x51A2.
  - START held high for 10 cycles must produce exactly one run.
- Abort/reset/clear:
  - EN=0 at edge k+2 of a run: IDLE, no IRQ, MAC_OUT holds the partial sum.
  - reset=1 mid-RUN: all outputs 0 on that edge.
  - CLR+START together in IDLE: MAC_OUT=0, no run starts.
